fu_lza_enc: RTL and testbench



---
 rtl/fu_lza_pkg.sv | 23 ++
 rtl/fu_lza_enc16.sv | 17 +
 rtl/fu_lza_enc.sv | 131 +++++++++++++
 tb/tb_fu_lza_enc.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_lza_pkg.sv
// Shared widths, result record and helpers for the pipelined LZA leading-one encoder.
package fu_lza_pkg;

  localparam int EDGE_W = 163;
  localparam int GRP_W  = 16;
  localparam int NGRP   = 11;
  localparam int AMT_W  = 8;
  localparam int TAG_W  = 4;
  localparam int PAD_W  = NGRP * GRP_W;

  typedef struct packed {
    logic [AMT_W-1:0] amt;
    logic             zero;
    logic             clamped;
    logic [TAG_W-1:0] tag;
  } lza_res_t;

  // Bit index of the first position covered by group g.
  function automatic logic [AMT_W-1:0] grp_base(input int g);
    return AMT_W'(g * GRP_W);
  endfunction

endpackage

// File: rtl/fu_lza_enc16.sv
// 16-bit combinational leading-one encoder; index 0 is the leftmost (highest priority) bit.
module fu_lza_enc16 (
  input  logic [15:0] vec,
  output logic        any,
  output logic [3:0]  pos
);

  always_comb begin
    any = |vec;
    pos = '0;
    // Scan downward so the lowest set index is the last one written.
    for (int j = 15; j >= 0; j--) begin
      if (vec[j]) pos = 4'(j);
    end
  end

endmodule

// File: rtl/fu_lza_enc.sv
// Two-stage leading-one encoder: S1 encodes 16-bit groups, S2 picks the first group and clamps.
module fu_lza_enc
  import fu_lza_pkg::*;
(
  input  logic                 nclk,
  input  logic                 rst_b,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:EDGE_W-1]    edge_vec,
  input  logic [AMT_W-1:0]     lz_max,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AMT_W-1:0]     lz_amt,
  output logic                 lz_zero,
  output logic                 lz_clamped,
  output logic [TAG_W-1:0]     out_tag
);

  logic s1_v_d, s1_v_q;
  logic s2_v_d, s2_v_q;
  logic s1_load, s2_load;

  logic [PAD_W-1:0]            pad_vec;
  logic [NGRP-1:0]             any_enc;
  logic [NGRP-1:0][3:0]        pos_enc;

  logic [NGRP-1:0]             s1_any_d, s1_any_q;
  logic [NGRP-1:0][3:0]        s1_pos_d, s1_pos_q;
  logic [AMT_W-1:0]            s1_max_d, s1_max_q;
  logic [TAG_W-1:0]            s1_tag_d, s1_tag_q;

  lza_res_t                    res_d, res_q;
  logic                        found;
  logic [AMT_W-1:0]            raw;

  // Handshake
  always_comb begin
    s2_load  = s1_v_q & (~s2_v_q | out_ready);
    in_ready = ~s1_v_q | s2_load;
    s1_load  = in_valid & in_ready;

    s1_v_d = s1_v_q;
    if (s1_load)      s1_v_d = 1'b1;
    else if (s2_load) s1_v_d = 1'b0;

    s2_v_d = s2_v_q;
    if (s2_load)        s2_v_d = 1'b1;
    else if (out_ready) s2_v_d = 1'b0;
  end

  always_ff @(posedge nclk or negedge rst_b) begin
    if (!rst_b) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
    end
  end

  // Stage 1: pad to a whole number of groups and encode each group.
  always_comb begin
    pad_vec = '0;
    for (int i = 0; i < EDGE_W; i++) begin
      pad_vec[i] = edge_vec[i];
    end
  end

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    fu_lza_enc16 u_enc16 (
      .vec (pad_vec[g*GRP_W +: GRP_W]),
      .any (any_enc[g]),
      .pos (pos_enc[g])
    );
  end

  always_comb begin
    s1_any_d = s1_any_q;
    s1_pos_d = s1_pos_q;
    s1_max_d = s1_max_q;
    s1_tag_d = s1_tag_q;
    if (s1_load) begin
      s1_any_d = any_enc;
      s1_pos_d = pos_enc;
      s1_max_d = lz_max;
      s1_tag_d = in_tag;
    end
  end

  always_ff @(posedge nclk) begin
    s1_any_q <= s1_any_d;
    s1_pos_q <= s1_pos_d;
    s1_max_q <= s1_max_d;
    s1_tag_q <= s1_tag_d;
  end

  // Stage 2: first non-empty group wins, then clamp against the caller's ceiling.
  always_comb begin
    found = 1'b0;
    raw   = '0;
    for (int g = NGRP - 1; g >= 0; g--) begin
      if (s1_any_q[g]) begin
        found = 1'b1;
        raw   = grp_base(g) + AMT_W'(s1_pos_q[g]);
      end
    end

    res_d = res_q;
    if (s2_load) begin
      res_d.tag     = s1_tag_q;
      res_d.zero    = ~found;
      res_d.clamped = found & (raw > s1_max_q);
      if (!found)             res_d.amt = '0;
      else if (raw > s1_max_q) res_d.amt = s1_max_q;
      else                     res_d.amt = raw;
    end
  end

  always_ff @(posedge nclk or negedge rst_b) begin
    if (!rst_b) res_q <= '0;
    else        res_q <= res_d;
  end

  assign out_valid  = s2_v_q;
  assign lz_amt     = res_q.amt;
  assign lz_zero    = res_q.zero;
  assign lz_clamped = res_q.clamped;
  assign out_tag    = res_q.tag;

endmodule

// File: tb/tb_fu_lza_enc.sv
// Self-checking bench for fu_lza_enc: directed table, corner sequences and random scoreboard.
module tb_fu_lza_enc;

  logic         nclk;
  logic         rst_b;
  logic         in_valid;
  logic         in_ready;
  logic [0:162] edge_vec;
  logic [7:0]   lz_max;
  logic [3:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   lz_amt;
  logic         lz_zero;
  logic         lz_clamped;
  logic [3:0]   out_tag;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;

  logic [13:0] exp_q[$];
  logic        stall_seen = 1'b0;
  logic [13:0] held;

  fu_lza_enc dut (
    .nclk       (nclk),
    .rst_b      (rst_b),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .edge_vec   (edge_vec),
    .lz_max     (lz_max),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .lz_amt     (lz_amt),
    .lz_zero    (lz_zero),
    .lz_clamped (lz_clamped),
    .out_tag    (out_tag)
  );

  initial nclk = 1'b0;
  always #5 nclk = ~nclk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Result packed as {amt[7:0], zero, clamped, tag[3:0]}.
  function automatic logic [13:0] ref_model(input logic [0:162] e, input logic [7:0] m,
                                            input logic [3:0] t);
    int first;
    first = -1;
    for (int i = 0; i < 163; i++) begin
      if (e[i] && first < 0) first = i;
    end
    if (first < 0) return {8'd0, 1'b1, 1'b0, t};
    if (first > int'(m)) return {m, 1'b0, 1'b1, t};
    return {8'(first), 1'b0, 1'b0, t};
  endfunction

  function automatic logic [0:162] mk_edge(input int a, input int b, input int c);
    logic [0:162] e;
    e = '0;
    if (a >= 0) e[a] = 1'b1;
    if (b >= 0) e[b] = 1'b1;
    if (c >= 0) e[c] = 1'b1;
    return e;
  endfunction

  // Scoreboard and output-stability monitor.
  always @(negedge nclk) begin
    if (!rst_b) begin
      exp_q.delete();
      stall_seen = 1'b0;
    end else begin
      if (stall_seen && out_valid)
        chk("hold_stable", {18'd0, lz_amt, lz_zero, lz_clamped, out_tag}, {18'd0, held});
      stall_seen = out_valid && !out_ready;
      held       = {lz_amt, lz_zero, lz_clamped, out_tag};
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got 0x%0h expected none",
                   {lz_amt, lz_zero, lz_clamped, out_tag});
        end else begin
          chk("result", {18'd0, lz_amt, lz_zero, lz_clamped, out_tag}, {18'd0, exp_q.pop_front()});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(edge_vec, lz_max, in_tag));
    end
  end

  // Present one vector and hold it until accepted; returns at posedge+1.
  task automatic put(input logic [0:162] e, input logic [7:0] m, input logic [3:0] t);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    edge_vec = e;
    lz_max   = m;
    in_tag   = t;
    for (int n = 0; n < 50; n++) begin
      @(negedge nclk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
      @(posedge nclk);
      #1;
    end
    chk("accept_in_time", {31'd0, acc}, 32'd1);
    @(posedge nclk);
    #1;
  endtask

  // Single vector into an empty pipe with exact 2-cycle latency check.
  task automatic send_one(input string name, input logic [0:162] e, input logic [7:0] m,
                          input logic [3:0] t, input logic [7:0] x_amt, input logic x_z,
                          input logic x_c);
    in_valid = 1'b1;
    edge_vec = e;
    lz_max   = m;
    in_tag   = t;
    @(negedge nclk);
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge nclk);
    #1;
    in_valid = 1'b0;
    chk({name, "_not_yet"}, {31'd0, out_valid}, 32'd0);
    @(posedge nclk);
    #1;
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk(name, {18'd0, lz_amt, lz_zero, lz_clamped, out_tag}, {18'd0, x_amt, x_z, x_c, t});
  endtask

  typedef struct {
    string        name;
    logic [0:162] e;
    logic [7:0]   m;
    logic [3:0]   t;
    logic [7:0]   amt;
    logic         z;
    logic         c;
  } vec_t;

  vec_t tv[10];

  initial begin
    int idx;
    int n0;
    logic acc;
    logic saw_block;
    int sent;
    logic [0:162] re;

    tv[0] = '{"all_zero",    mk_edge(-1, -1, -1), 8'd10,  4'h1, 8'd0,   1'b1, 1'b0};
    tv[1] = '{"multi_bit",   mk_edge(37, 40, 150), 8'd255, 4'h2, 8'd37,  1'b0, 1'b0};
    tv[2] = '{"clamp_64",    mk_edge(100, -1, -1), 8'd64,  4'h3, 8'd64,  1'b0, 1'b1};
    tv[3] = '{"eq_max_100",  mk_edge(100, -1, -1), 8'd100, 4'h4, 8'd100, 1'b0, 1'b0};
    tv[4] = '{"bit0_max0",   mk_edge(0, 5, -1),    8'd0,   4'h5, 8'd0,   1'b0, 1'b0};
    tv[5] = '{"bit5_max4",   mk_edge(5, 9, -1),    8'd4,   4'h6, 8'd4,   1'b0, 1'b1};
    tv[6] = '{"last_max162", mk_edge(162, -1, -1), 8'd162, 4'h7, 8'd162, 1'b0, 1'b0};
    tv[7] = '{"last_max161", mk_edge(162, -1, -1), 8'd161, 4'h8, 8'd161, 1'b0, 1'b1};
    tv[8] = '{"grp_edge_16", mk_edge(16, 31, -1),  8'd200, 4'h9, 8'd16,  1'b0, 1'b0};
    tv[9] = '{"grp_edge_15", mk_edge(15, 16, -1),  8'd200, 4'hA, 8'd15,  1'b0, 1'b0};

    rst_b     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    edge_vec  = '0;
    lz_max    = '0;
    in_tag    = '0;
    repeat (3) @(posedge nclk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_outputs", {18'd0, lz_amt, lz_zero, lz_clamped, out_tag}, 32'd0);
    @(negedge nclk);
    rst_b = 1'b1;
    @(posedge nclk);
    #1;

    for (int i = 0; i < 10; i++)
      send_one(tv[i].name, tv[i].e, tv[i].m, tv[i].t, tv[i].amt, tv[i].z, tv[i].c);
    repeat (2) @(posedge nclk);
    #1;

    // Single-bit sweep at full throughput.
    for (int k = 0; k < 163; k++) put(mk_edge(k, -1, -1), 8'd255, 4'(k));
    in_valid = 1'b0;
    repeat (3) @(posedge nclk);
    #1;

    // Backpressure: five vectors, out_ready low for cycles 3..6.
    n0 = n_out;
    idx = 0;
    acc = 1'b0;
    saw_block = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (acc) idx++;
      out_ready = !(c >= 3 && c <= 6);
      if (idx < 5) begin
        in_valid = 1'b1;
        edge_vec = mk_edge(idx + 1, -1, -1);
        lz_max   = 8'd255;
        in_tag   = 4'(idx + 1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge nclk);
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (c == 7) chk("no_bubble_release", {31'd0, in_ready}, 32'd1);
      @(posedge nclk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge nclk);
    #1;
    chk("bp_in_ready_low", {31'd0, saw_block}, 32'd1);
    chk("bp_count", n_out - n0, 32'd5);
    chk("bp_queue_empty", exp_q.size(), 32'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    put(mk_edge(20, -1, -1), 8'd255, 4'hB);
    put(mk_edge(21, -1, -1), 8'd255, 4'hC);
    in_valid = 1'b0;
    chk("full_out_valid", {31'd0, out_valid}, 32'd1);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    #1;
    rst_b = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge nclk);
    @(negedge nclk);
    rst_b     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge nclk);
      #1;
      chk("no_stale_after_rst", {31'd0, out_valid}, 32'd0);
    end
    send_one("post_rst", mk_edge(7, 90, -1), 8'd255, 4'hD, 8'd7, 1'b0, 1'b0);
    @(posedge nclk);
    #1;

    // Random traffic with random backpressure against the reference model.
    sent = 0;
    acc  = 1'b0;
    for (int c = 0; c < 3000 && sent < 400; c++) begin
      if (acc) in_valid = 1'b0;
      out_ready = ($urandom_range(3) != 0);
      if (!in_valid && $urandom_range(3) != 0) begin
        re = '0;
        if ($urandom_range(7) != 0) begin
          for (int b = 0; b <= int'($urandom_range(3)); b++) re[$urandom_range(162)] = 1'b1;
        end
        in_valid = 1'b1;
        edge_vec = re;
        lz_max   = 8'($urandom_range(255));
        in_tag   = 4'($urandom_range(15));
      end
      @(negedge nclk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      @(posedge nclk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge nclk);
    #1;
    chk("rand_sent", sent, 32'd400);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
